// File: rtl/multi_cycle_sequencer_if.sv
// Handshake/bus bundle between the multi-cycle datapath and its sequencer.
// The datapath side (master) supplies the instruction fields and the memory
// ready strobe; the sequencer side (slave) returns write enables, debug state
// and the retired-instruction / cycle counters.
interface multi_cycle_sequencer_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       op;
  logic [5:0]       func;
  logic             MemReady;
  logic             PCWrite;
  logic             IRWrite;
  logic             RegWrite;
  logic             MemWrite;
  logic             MemRead;
  logic [3:0]       State;
  logic             Halted;
  logic [CNT_W-1:0] InsCount;
  logic [CNT_W-1:0] CycCount;

  modport master (
    output op, func, MemReady,
    input  PCWrite, IRWrite, RegWrite, MemWrite, MemRead,
    input  State, Halted, InsCount, CycCount
  );

  modport slave (
    input  op, func, MemReady,
    output PCWrite, IRWrite, RegWrite, MemWrite, MemRead,
    output State, Halted, InsCount, CycCount
  );
endinterface

// File: rtl/multi_cycle_sequencer.sv
// Five-phase (IF/ID/EXE/MEM/WB) sequencer for the multi-cycle MIPS datapath.
// Decides only *when* PC, IR, register file and data memory are written; mux
// selects and ALUOp stay with the static opcode decoder. Stalls in MEM until
// MemReady, and counts retired instructions and non-halted cycles.
module multi_cycle_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic                   CLK,
  input  logic                   Reset,
  multi_cycle_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    S_IF    = 4'b0000,
    S_ID    = 4'b0001,
    S_EXE_L = 4'b0010,
    S_MEM   = 4'b0011,
    S_WB_L  = 4'b0100,
    S_EXE_B = 4'b0101,
    S_EXE_A = 4'b0110,
    S_WB_A  = 4'b0111,
    S_HALT  = 4'b1000
  } state_t;

  typedef enum logic [2:0] {
    C_JUMP,
    C_JAL,
    C_HALT,
    C_BRANCH,
    C_LDST,
    C_ALU
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLTZ  = 6'b000110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Opcode class that steers the ID-state branch; jr hides under R-type.
  function automatic iclass_t classify(input logic [5:0] op, input logic [5:0] func);
    iclass_t c;
    if (op == OP_J || (op == OP_RTYPE && func == FN_JR)) c = C_JUMP;
    else if (op == OP_JAL)                               c = C_JAL;
    else if (op == OP_HALT)                              c = C_HALT;
    else if (op == OP_BEQ || op == OP_BNE || op == OP_BLTZ) c = C_BRANCH;
    else if (op == OP_LW || op == OP_SW)                 c = C_LDST;
    else                                                 c = C_ALU;
    return c;
  endfunction

  state_t           state_p0;
  state_t           state_nxt;
  logic             pc_w;
  logic             ir_w;
  logic             rf_w;
  logic             dm_w;
  logic             dm_r;
  logic [CNT_W-1:0] ins_cnt_p0;
  logic [CNT_W-1:0] cyc_cnt_p0;

  // Next-state and enable decode from the registered state (Mealy on op/MemReady).
  always_comb begin
    state_nxt = S_IF;
    pc_w      = 1'b0;
    ir_w      = 1'b0;
    rf_w      = 1'b0;
    dm_w      = 1'b0;
    dm_r      = 1'b0;
    case (state_p0)
      S_IF: begin
        ir_w      = 1'b1;
        state_nxt = S_ID;
      end
      S_ID: begin
        case (classify(bus.op, bus.func))
          C_JUMP: begin
            pc_w      = 1'b1;
            state_nxt = S_IF;
          end
          C_JAL: begin
            rf_w      = 1'b1;
            pc_w      = 1'b1;
            state_nxt = S_IF;
          end
          C_HALT:   state_nxt = S_HALT;
          C_BRANCH: state_nxt = S_EXE_B;
          C_LDST:   state_nxt = S_EXE_L;
          default:  state_nxt = S_EXE_A;
        endcase
      end
      S_EXE_A: state_nxt = S_WB_A;
      // Taken/not-taken is resolved by the PC mux, so PC is always loaded here.
      S_EXE_B: begin
        pc_w      = 1'b1;
        state_nxt = S_IF;
      end
      S_EXE_L: state_nxt = S_MEM;
      S_MEM: begin
        if (bus.op == OP_SW) begin
          dm_w = 1'b1;
          if (bus.MemReady) begin
            pc_w      = 1'b1;
            state_nxt = S_IF;
          end else begin
            state_nxt = S_MEM;
          end
        end else begin
          dm_r      = 1'b1;
          state_nxt = bus.MemReady ? S_WB_L : S_MEM;
        end
      end
      S_WB_A, S_WB_L: begin
        rf_w      = 1'b1;
        pc_w      = 1'b1;
        state_nxt = S_IF;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IF;
    endcase
  end

  // State register; async reset drops back to IF from any point of an instruction.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_p0 <= S_IF;
    else        state_p0 <= state_nxt;
  end

  // Retired-instruction and running-cycle counters, both free-wrapping.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      ins_cnt_p0 <= '0;
      cyc_cnt_p0 <= '0;
    end else begin
      if (pc_w)               ins_cnt_p0 <= ins_cnt_p0 + CNT_ONE;
      if (state_p0 != S_HALT) cyc_cnt_p0 <= cyc_cnt_p0 + CNT_ONE;
    end
  end

  // Enables are held low for as long as Reset is asserted, not just at the edge.
  assign bus.PCWrite  = pc_w & Reset;
  assign bus.IRWrite  = ir_w & Reset;
  assign bus.RegWrite = rf_w & Reset;
  assign bus.MemWrite = dm_w & Reset;
  assign bus.MemRead  = dm_r & Reset;
  assign bus.State    = state_p0;
  assign bus.Halted   = (state_p0 == S_HALT);
  assign bus.InsCount = ins_cnt_p0;
  assign bus.CycCount = cyc_cnt_p0;

endmodule

// File: tb/tb_multi_cycle_sequencer.sv
// Bench for multi_cycle_sequencer: a 32-bit-counter instance and a 4-bit-counter
// instance run in lockstep on identical stimulus. The reference model expands
// each instruction into its expected per-cycle phase list from the opcode class.
module tb_multi_cycle_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multi_cycle_sequencer_if #(.CNT_W(32)) bus32();
  multi_cycle_sequencer_if #(.CNT_W(4))  bus4();

  assign bus4.op       = bus32.op;
  assign bus4.func     = bus32.func;
  assign bus4.MemReady = bus32.MemReady;

  multi_cycle_sequencer #(.CNT_W(32)) dut32 (.CLK(clk), .Reset(rst_n), .bus(bus32.slave));
  multi_cycle_sequencer #(.CNT_W(4))  dut4  (.CLK(clk), .Reset(rst_n), .bus(bus4.slave));

  localparam logic [3:0] ST_IF = 4'b0000, ST_ID = 4'b0001, ST_EXE_A = 4'b0110,
                         ST_EXE_B = 4'b0101, ST_EXE_L = 4'b0010, ST_MEM = 4'b0011,
                         ST_WB_A = 4'b0111, ST_WB_L = 4'b0100, ST_HALT = 4'b1000;
  // enable vectors {PCWrite, IRWrite, RegWrite, MemWrite, MemRead}
  localparam logic [4:0] E_NONE = 5'b00000, E_IR = 5'b01000, E_PC = 5'b10000,
                         E_RWPC = 5'b10100, E_MW = 5'b00010, E_MWPC = 5'b10010,
                         E_MR = 5'b00001;

  typedef struct packed {
    logic [3:0] st;
    logic [4:0] en;
    logic       fixed;
    logic       rdy;
  } cyc_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_ins = 0;
  logic [31:0] exp_cyc = 0;

  function automatic cyc_t mk(input logic [3:0] st, input logic [4:0] en,
                              input logic fixed, input logic rdy);
    cyc_t c;
    c.st = st; c.en = en; c.fixed = fixed; c.rdy = rdy;
    return c;
  endfunction

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus32.State, bus32.PCWrite, bus32.IRWrite, bus32.RegWrite, bus32.MemWrite,
         bus32.MemRead, bus32.Halted} !== 10'd0) begin
      failures++;
      $display("FAIL reset_outputs32 got state=%b en=%b%b%b%b%b halted=%b want all zero",
               bus32.State, bus32.PCWrite, bus32.IRWrite, bus32.RegWrite,
               bus32.MemWrite, bus32.MemRead, bus32.Halted);
    end
    checks++;
    if (bus32.InsCount !== 32'd0 || bus32.CycCount !== 32'd0 ||
        bus4.InsCount !== 4'd0 || bus4.CycCount !== 4'd0) begin
      failures++;
      $display("FAIL reset_counters got ins=%0d cyc=%0d ins4=%0d cyc4=%0d want 0",
               bus32.InsCount, bus32.CycCount, bus4.InsCount, bus4.CycCount);
    end
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_ins = 0;
    exp_cyc = 0;
  endtask

  // Runs one instruction; abort_at >= 0 asserts reset asynchronously inside that cycle.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input int stalls, input int abort_at);
    cyc_t q[$];
    logic [9:0] obs;
    logic [9:0] expv;
    q.push_back(mk(ST_IF, E_IR, 1'b0, 1'b0));
    if (o == 6'b000010 || (o == 6'b000000 && f == 6'b001000)) begin
      q.push_back(mk(ST_ID, E_PC, 1'b0, 1'b0));
    end else if (o == 6'b000011) begin
      q.push_back(mk(ST_ID, E_RWPC, 1'b0, 1'b0));
    end else if (o == 6'b111111) begin
      q.push_back(mk(ST_ID, E_NONE, 1'b0, 1'b0));
      repeat (20) q.push_back(mk(ST_HALT, E_NONE, 1'b0, 1'b0));
    end else if (o == 6'b000100 || o == 6'b000101 || o == 6'b000110) begin
      q.push_back(mk(ST_ID, E_NONE, 1'b0, 1'b0));
      q.push_back(mk(ST_EXE_B, E_PC, 1'b0, 1'b0));
    end else if (o == 6'b100011) begin
      q.push_back(mk(ST_ID, E_NONE, 1'b0, 1'b0));
      q.push_back(mk(ST_EXE_L, E_NONE, 1'b0, 1'b0));
      repeat (stalls) q.push_back(mk(ST_MEM, E_MR, 1'b1, 1'b0));
      q.push_back(mk(ST_MEM, E_MR, 1'b1, 1'b1));
      q.push_back(mk(ST_WB_L, E_RWPC, 1'b0, 1'b0));
    end else if (o == 6'b101011) begin
      q.push_back(mk(ST_ID, E_NONE, 1'b0, 1'b0));
      q.push_back(mk(ST_EXE_L, E_NONE, 1'b0, 1'b0));
      repeat (stalls) q.push_back(mk(ST_MEM, E_MW, 1'b1, 1'b0));
      q.push_back(mk(ST_MEM, E_MWPC, 1'b1, 1'b1));
    end else begin
      q.push_back(mk(ST_ID, E_NONE, 1'b0, 1'b0));
      q.push_back(mk(ST_EXE_A, E_NONE, 1'b0, 1'b0));
      q.push_back(mk(ST_WB_A, E_RWPC, 1'b0, 1'b0));
    end
    bus32.op   = o;
    bus32.func = f;
    for (int i = 0; i < q.size(); i++) begin
      bus32.MemReady = q[i].fixed ? q[i].rdy : 1'($urandom_range(0, 1));
      @(negedge clk);
      expv = {q[i].st, q[i].en, q[i].st == ST_HALT};
      obs  = {bus32.State, bus32.PCWrite, bus32.IRWrite, bus32.RegWrite,
              bus32.MemWrite, bus32.MemRead, bus32.Halted};
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL ctrl32 op=%b cyc%0d got st/en/h=%b want %b", o, i, obs, expv);
      end
      obs = {bus4.State, bus4.PCWrite, bus4.IRWrite, bus4.RegWrite,
             bus4.MemWrite, bus4.MemRead, bus4.Halted};
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL ctrl4 op=%b cyc%0d got st/en/h=%b want %b", o, i, obs, expv);
      end
      checks++;
      if (bus32.InsCount !== exp_ins || bus32.CycCount !== exp_cyc) begin
        failures++;
        $display("FAIL count32 op=%b cyc%0d got ins=%0d cyc=%0d want ins=%0d cyc=%0d",
                 o, i, bus32.InsCount, bus32.CycCount, exp_ins, exp_cyc);
      end
      checks++;
      if (bus4.InsCount !== exp_ins[3:0] || bus4.CycCount !== exp_cyc[3:0]) begin
        failures++;
        $display("FAIL count4 op=%b cyc%0d got ins=%0d cyc=%0d want ins=%0d cyc=%0d",
                 o, i, bus4.InsCount, bus4.CycCount, exp_ins[3:0], exp_cyc[3:0]);
      end
      if (i == abort_at) begin
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus32.MemWrite !== 1'b0 || bus32.PCWrite !== 1'b0 || bus32.State !== ST_IF) begin
          failures++;
          $display("FAIL async_reset got mw=%b pc=%b st=%b want 0 0 0000",
                   bus32.MemWrite, bus32.PCWrite, bus32.State);
        end
        checks++;
        if (bus32.InsCount !== 32'd0 || bus32.CycCount !== 32'd0) begin
          failures++;
          $display("FAIL async_reset_cnt got ins=%0d cyc=%0d want 0 0",
                   bus32.InsCount, bus32.CycCount);
        end
        exp_ins = 0;
        exp_cyc = 0;
        return;
      end
      @(posedge clk);
      if (q[i].en[4]) exp_ins = exp_ins + 1;
      if (q[i].st != ST_HALT) exp_cyc = exp_cyc + 1;
      #1;
    end
  endtask

  task automatic test_reset();
    bus32.op = 6'b0; bus32.func = 6'b0; bus32.MemReady = 1'b0;
    do_reset(3);
  endtask

  task automatic test_alu();
    run_instr(6'b000000, 6'b100000, 0, -1);
    checks++;
    if (bus32.InsCount !== 32'd1) begin
      failures++;
      $display("FAIL alu_inscount got %0d want 1", bus32.InsCount);
    end
    run_instr(6'b001000, 6'b010101, 0, -1);
    run_instr(6'b001101, 6'b000000, 0, -1);
  endtask

  task automatic test_lw();
    run_instr(6'b100011, 6'b000000, 2, -1);
    run_instr(6'b100011, 6'b111111, 0, -1);
  endtask

  task automatic test_sw();
    run_instr(6'b101011, 6'b000000, 0, -1);
    run_instr(6'b101011, 6'b001000, 1, -1);
  endtask

  task automatic test_jumps();
    do_reset(1);
    run_instr(6'b000011, 6'b000000, 0, -1);
    run_instr(6'b000010, 6'b000000, 0, -1);
    run_instr(6'b000000, 6'b001000, 0, -1);
    run_instr(6'b000100, 6'b000000, 0, -1);
    checks++;
    if (bus32.InsCount !== 32'd4) begin
      failures++;
      $display("FAIL jumps_inscount got %0d want 4", bus32.InsCount);
    end
  endtask

  task automatic test_halt();
    do_reset(1);
    run_instr(6'b000000, 6'b100010, 0, -1);
    run_instr(6'b000101, 6'b000000, 0, -1);
    run_instr(6'b111111, 6'b000000, 0, -1);
    checks++;
    if (bus32.InsCount !== 32'd2 || bus32.CycCount !== 32'd9 || bus32.Halted !== 1'b1) begin
      failures++;
      $display("FAIL halt_frozen got ins=%0d cyc=%0d halted=%b want 2 9 1",
               bus32.InsCount, bus32.CycCount, bus32.Halted);
    end
    do_reset(1);
    run_instr(6'b000010, 6'b000000, 0, -1);
  endtask

  task automatic test_async_reset();
    do_reset(1);
    run_instr(6'b101011, 6'b000000, 3, 4);
    do_reset(1);
    run_instr(6'b000000, 6'b100000, 0, -1);
  endtask

  task automatic test_wrap();
    do_reset(1);
    for (int k = 0; k < 16; k++) run_instr(6'b000010, 6'b000000, 0, -1);
    checks++;
    if (bus4.InsCount !== 4'd0 || bus32.InsCount !== 32'd16) begin
      failures++;
      $display("FAIL wrap got ins4=%0d ins32=%0d want 0 16", bus4.InsCount, bus32.InsCount);
    end
  endtask

  task automatic test_random();
    logic [5:0] o;
    logic [5:0] f;
    logic [5:0] pool [8];
    pool = '{6'b000010, 6'b000011, 6'b000100, 6'b000101, 6'b000110,
             6'b100011, 6'b101011, 6'b000000};
    do_reset(2);
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 0) o = pool[$urandom_range(0, 7)];
      else o = 6'($urandom_range(0, 62));
      f = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom_range(0, 63));
      run_instr(o, f, $urandom_range(0, 3), -1);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lw();
    test_sw();
    test_jumps();
    test_halt();
    test_async_reset();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_cycle_sequencer.md
Name: multi_cycle_sequencer

Overview:
- Five-phase state machine (IF, ID, EXE, MEM, WB) that sequences the multi-cycle MIPS datapath.
- Takes the current instruction's op/func from the instruction register.
- Issues per-cycle write enables: PC, IR, register file, data memory. The static opcode decoder keeps supplying mux selects and ALUOp; this block gates only *when* state changes.
- Also stalls on a memory-ready handshake and keeps retired-instruction and cycle counters.

Parameters:
- CNT_W, 32, width of InsCount and CycCount.

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- Reset  input  1  asynchronous, active-low reset
- op  input  6  opcode field from instruction register
- func  input  6  function field from instruction register
- MemReady  input  1  data memory access complete this cycle
- PCWrite  output  1  load PC at end of cycle
- IRWrite  output  1  load instruction register at end of cycle
- RegWrite  output  1  register file write enable
- MemWrite  output  1  data memory write strobe
- MemRead  output  1  data memory read enable
- State  output  4  current state encoding, for debug/display
- Halted  output  1  high while in HALT
- InsCount  output  CNT_W  instructions retired
- CycCount  output  CNT_W  cycles since reset, frozen in HALT

Behaviour:
- Clock and reset: one clock CLK; Reset is asynchronous, active-low.
- Reset (Reset=0, any time, including mid-instruction):
  - State=IF, InsCount=0, CycCount=0.
  - All enables forced 0 while Reset=0.
  - First IF cycle begins on the first rising edge after release.
- State encodings:
  - IF=0000, ID=0001
  - EXE_A=0110, EXE_B=0101, EXE_L=0010
  - MEM=0011
  - WB_A=0111, WB_L=0100
  - HALT=1000
  - Any other encoding -> IF next edge.
- Outputs are Moore/Mealy-on-op combinational decode of registered State; all enables low except as listed below.
- IF: IRWrite=1 -> ID.
- ID (opcode classes):
  - j=000010, or jr (op=000000, func=001000): PCWrite=1 -> IF.
  - jal=000011: RegWrite=1, PCWrite=1 -> IF.
  - halt=111111: no enables -> HALT.
  - beq=000100, bne=000101, bltz=000110: -> EXE_B.
  - lw=100011, sw=101011: -> EXE_L.
  - All other opcodes (R-type, addi, ori, slti, etc.): -> EXE_A.
- EXE_A: -> WB_A.
- EXE_B: PCWrite=1 -> IF. The PC mux resolves taken/not-taken from the ALU zero flag; the sequencer writes unconditionally.
- EXE_L: -> MEM.
- MEM, sw:
  - MemWrite=1 while in state.
  - If MemReady=1: PCWrite=1 -> IF; else stay.
- MEM, lw:
  - MemRead=1 while in state.
  - If MemReady=1: -> WB_L; else stay.
- WB_A and WB_L: RegWrite=1, PCWrite=1 -> IF.
- HALT: all enables 0, stays until Reset. Halted=1.
- MemReady is ignored outside MEM. MemWrite/MemRead are never asserted outside MEM.
- Invariant: PCWrite is high in exactly one cycle per retired instruction; halt retires nothing.
- op/func are sampled combinationally each cycle. They must be stable from the cycle after IF until the instruction's last state, which holds because IR loads only in IF.
- InsCount:
  - Increments by 1 on each rising edge where PCWrite=1.
  - Wraps from all-ones to 0.
- CycCount:
  - Increments every edge where State != HALT and Reset=1.
  - Wraps from all-ones to 0.
- Instruction latencies in cycles (MemReady=1):
  - j/jr/jal: 2
  - branch: 3
  - R-type/I-type ALU: 4
  - sw: 4
  - lw: 5
  - Each MemReady=0 cycle in MEM adds 1.

Test Plan:
- Reset low 3 cycles, release, op=000000 func=100000 (add):
  - States IF,ID,EXE_A,WB_A.
  - RegWrite and PCWrite both high only in the 4th cycle.
  - InsCount=1 after 4 cycles.
- op=100011 (lw), MemReady low 2 cycles then high:
  - States IF,ID,EXE_L,MEM,MEM,MEM,WB_L.
  - MemRead high for 3 cycles; RegWrite+PCWrite in WB_L.
  - Latency 7.
- op=101011 (sw), MemReady=1:
  - MemWrite high exactly 1 cycle in MEM, with PCWrite the same cycle.
  - RegWrite never high.
- Sequence jal, j, jr (func=001000), beq:
  - Each 2/2/2/3 cycles.
  - RegWrite high only in jal's ID cycle.
  - InsCount=4 at end.
- op=111111 (halt) after 2 instructions:
  - Halted=1, State=1000, all enables 0.
  - InsCount=2 and CycCount frozen for 20 cycles.
  - Reset pulse returns State=0000 and zeroes both counters.
- Reset asserted asynchronously mid-MEM of sw:
  - MemWrite drops immediately, no PCWrite.
  - Post-release State=IF, InsCount=0.
- With CNT_W=4:
  - After 16 retired instructions InsCount wraps to 0.
